// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM with per-lane write enables, a post-reset clear
// sweep, configurable read latency and read/write collision policy.
module dual_port_ram_be #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8,
  parameter int BYTE_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int RW_MODE    = 0,
  localparam int NBE       = WIDTH / BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      din,
  input  logic                  we,
  input  logic [NBE-1:0]        be,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic                  init_busy
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  logic [WIDTH-1:0] ram [DEPTH];

  logic             w_ok;
  logic             r_ok;
  logic             wr_acc;
  logic             rd_acc;
  logic             hit;
  logic [WIDTH-1:0] old_word;
  logic [WIDTH-1:0] new_word;
  logic [WIDTH-1:0] rd_word;

  always_comb begin
    w_ok   = {1'b0, w_addr} < DEPTH_L;
    r_ok   = {1'b0, r_addr} < DEPTH_L;
    wr_acc = (state == READY) && we && w_ok;
    rd_acc = (state == READY) && re;
    hit    = wr_acc && r_ok && (w_addr == r_addr);
  end

  always_comb begin
    old_word = '0;
    if (r_ok) old_word = ram[r_addr];
  end

  // Merged word a write-first collision must return.
  always_comb begin
    new_word = old_word;
    for (int i = 0; i < NBE; i++) begin
      if (be[i])
        new_word[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    rd_word = old_word;
    if (RW_MODE == 1 && hit) rd_word = new_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      init_busy <= 1'b1;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          if (clr_cnt == LAST) begin
            state     <= READY;
            init_busy <= 1'b0;
            clr_cnt   <= '0;
          end
        end
        READY: begin
          state     <= READY;
          init_busy <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; contents come from the sweep.
  always_ff @(posedge clk) begin
    if (state == CLEAR && !rst) begin
      ram[clr_cnt] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NBE; i++) begin
        if (be[i])
          ram[w_addr][i*BYTE_W +: BYTE_W] <=
            din[i*BYTE_W +: BYTE_W];
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic             s1_v;
    logic [WIDTH-1:0] s1_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_v       <= 1'b0;
        s1_d       <= '0;
        dout       <= '0;
        dout_valid <= 1'b0;
      end else begin
        s1_v       <= rd_acc;
        dout_valid <= s1_v;
        if (rd_acc) s1_d <= rd_word;
        if (s1_v) dout <= s1_d;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout       <= '0;
        dout_valid <= 1'b0;
      end else begin
        dout_valid <= rd_acc;
        if (rd_acc) dout <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: two configurations driven in lockstep and
// compared every cycle against a queue-based reference model.
module tb_dual_port_ram_be;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        we;
  logic [1:0]  be;
  logic [2:0]  w_addr;
  logic        re;
  logic [2:0]  r_addr;

  logic [7:0]  dout0;
  logic        dv0;
  logic        busy0;
  logic [15:0] dout1;
  logic        dv1;
  logic        busy1;

  always #5 clk = ~clk;

  dual_port_ram_be #(
    .WIDTH(8), .ADDR_WIDTH(3), .DEPTH(8),
    .BYTE_W(8), .RD_LATENCY(1), .RW_MODE(0)
  ) u0 (
    .clk(clk), .rst(rst), .din(din[7:0]), .we(we),
    .be(be[0:0]), .w_addr(w_addr), .re(re), .r_addr(r_addr),
    .dout(dout0), .dout_valid(dv0), .init_busy(busy0)
  );

  dual_port_ram_be #(
    .WIDTH(16), .ADDR_WIDTH(3), .DEPTH(6),
    .BYTE_W(8), .RD_LATENCY(2), .RW_MODE(1)
  ) u1 (
    .clk(clk), .rst(rst), .din(din), .we(we),
    .be(be), .w_addr(w_addr), .re(re), .r_addr(r_addr),
    .dout(dout1), .dout_valid(dv1), .init_busy(busy1)
  );

  typedef struct {
    int          due;
    logic [15:0] d;
  } rd_t;

  logic [15:0] m0 [8];
  logic [15:0] m1 [8];
  rd_t         q0 [$];
  rd_t         q1 [$];
  int          clr0;
  int          clr1;
  int          cyc;
  logic [15:0] e_dout0;
  logic [15:0] e_dout1;
  logic        e_dv0;
  logic        e_dv1;
  int          checks;
  int          failures;

  function automatic logic [15:0] merge(
    input logic [15:0] old,
    input logic [15:0] nw,
    input logic [1:0]  b
  );
    logic [15:0] r;
    r = old;
    if (b[0]) r[7:0]  = nw[7:0];
    if (b[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h",
             tag, cyc, obs, exp);
    end
  endtask

  // Reference behaviour at one rising edge, from the current inputs.
  task automatic model_edge();
    rd_t t;
    cyc++;
    if (rst) begin
      clr0 = 8;
      clr1 = 6;
      q0.delete();
      q1.delete();
      e_dout0 = '0;
      e_dout1 = '0;
      e_dv0   = 1'b0;
      e_dv1   = 1'b0;
      return;
    end
    if (clr0 > 0) begin
      m0[8 - clr0] = '0;
      clr0--;
    end else begin
      if (re) q0.push_back('{cyc, m0[r_addr]});
      if (we && be[0]) m0[w_addr] = {8'h00, din[7:0]};
    end
    if (clr1 > 0) begin
      m1[6 - clr1] = '0;
      clr1--;
    end else begin
      if (we && w_addr < 3'd6)
        m1[w_addr] = merge(m1[w_addr], din, be);
      if (re)
        q1.push_back('{cyc + 1,
          (r_addr < 3'd6) ? m1[r_addr] : 16'h0000});
    end
    e_dv0 = 1'b0;
    if (q0.size() > 0 && q0[0].due == cyc) begin
      t = q0.pop_front();
      e_dv0   = 1'b1;
      e_dout0 = t.d;
    end
    e_dv1 = 1'b0;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      t = q1.pop_front();
      e_dv1   = 1'b1;
      e_dout1 = t.d;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy0", {15'b0, busy0}, {15'b0, clr0 > 0});
    chk("dv0",   {15'b0, dv0},   {15'b0, e_dv0});
    chk("dout0", {8'h00, dout0}, e_dout0);
    chk("busy1", {15'b0, busy1}, {15'b0, clr1 > 0});
    chk("dv1",   {15'b0, dv1},   {15'b0, e_dv1});
    chk("dout1", dout1,          e_dout1);
  endtask

  task automatic op(
    input logic        w,
    input logic [1:0]  b,
    input logic [2:0]  wa,
    input logic [15:0] d,
    input logic        r,
    input logic [2:0]  ra
  );
    we     = w;
    be     = b;
    w_addr = wa;
    din    = d;
    re     = r;
    r_addr = ra;
    cycle();
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst      = 1'b1;
    we       = 1'b0;
    be       = 2'b00;
    din      = '0;
    w_addr   = '0;
    re       = 1'b0;
    r_addr   = '0;
    for (int i = 0; i < 8; i++) begin
      m0[i] = 'x;
      m1[i] = 'x;
    end
    repeat (2) cycle();
    chk("rst_busy0", {15'b0, busy0}, 16'h0001);
    chk("rst_dout1", dout1, 16'h0000);

    // Sweep with a read held on address 0.
    #1;
    rst    = 1'b0;
    re     = 1'b1;
    r_addr = 3'd0;
    repeat (8) cycle();
    chk("sweep_done0", {15'b0, busy0}, 16'h0000);
    for (int a = 0; a < 8; a++) op(0, 2'b00, 0, 0, 1, 3'(a));
    op(0, 2'b00, 0, 0, 0, 0);
    op(0, 2'b00, 0, 0, 0, 0);

    // Lane merge on address 3.
    op(1, 2'b11, 3, 16'hABCD, 0, 0);
    op(1, 2'b01, 3, 16'h1234, 0, 0);
    op(0, 2'b00, 0, 0, 1, 3);
    chk("lane_u0", {8'h00, dout0}, 16'h0034);
    op(0, 2'b00, 0, 0, 0, 0);
    chk("lane_u1", dout1, 16'hAB34);

    // Same-address collision.
    op(1, 2'b11, 5, 16'h0011, 0, 0);
    op(1, 2'b11, 5, 16'h0022, 1, 5);
    chk("coll_rf_u0", {8'h00, dout0}, 16'h0011);
    op(0, 2'b00, 0, 0, 1, 5);
    chk("coll_next_u0", {8'h00, dout0}, 16'h0022);
    chk("coll_wf_u1", dout1, 16'h0022);
    op(0, 2'b00, 0, 0, 0, 0);
    op(0, 2'b00, 0, 0, 0, 0);

    // Back-to-back reads through the pipeline.
    for (int a = 0; a < 8; a++) op(0, 2'b00, 0, 0, 1, 3'(a));
    repeat (3) op(0, 2'b00, 0, 0, 0, 0);

    // Out-of-range address and empty lane mask.
    op(1, 2'b11, 7, 16'hFFFF, 0, 0);
    op(0, 2'b00, 0, 0, 1, 7);
    chk("oor_u0", {8'h00, dout0}, 16'h00FF);
    op(0, 2'b00, 0, 0, 0, 0);
    chk("oor_u1", dout1, 16'h0000);
    chk("oor_dv1", {15'b0, dv1}, 16'h0001);
    for (int a = 0; a < 6; a++) op(0, 2'b00, 0, 0, 1, 3'(a));
    op(1, 2'b00, 2, 16'hBEEF, 0, 0);
    op(0, 2'b00, 0, 0, 1, 2);
    repeat (2) op(0, 2'b00, 0, 0, 0, 0);

    // Random traffic.
    repeat (400)
      op(1'($urandom), 2'($urandom), 3'($urandom),
         16'($urandom), 1'($urandom), 3'($urandom));

    // Reset with a read in flight, then a mid-sweep reset.
    op(0, 2'b00, 0, 0, 1, 1);
    #1;
    rst = 1'b1;
    cycle();
    #1;
    rst = 1'b0;
    repeat (4) cycle();
    chk("mid_busy0", {15'b0, busy0}, 16'h0001);
    #1;
    rst = 1'b1;
    cycle();
    #1;
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 20) begin
      cycle();
      n++;
    end
    chk("sweep_len", 16'(n), 16'd8);

    repeat (300)
      op(1'($urandom), 2'($urandom), 3'($urandom),
         16'($urandom), 1'($urandom), 3'($urandom));
    repeat (3) op(0, 2'b00, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
